// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and constants for the 1-to-4 demux sequencer
//               and anything that drives or observes the demux stage.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Demux select width and number of output slots
  localparam int ADDR_W    = 2;
  localparam int NUM_SLOTS = 4;

  // Index of the final slot in a frame
  localparam logic [ADDR_W-1:0] c_LAST_SLOT = ADDR_W'(NUM_SLOTS - 1);

  // Sequencer state encoding; code 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : slot_timer
// Description : Free-running modulo-TICK_DIV counter with synchronous clear.
//               o_tc is high on the last cycle of each slot.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tc
);

  // Counter width, never narrower than one bit so TICK_DIV=1 still builds
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_TC_VAL = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == c_TC_VAL);
  assign o_tc = w_tc;

  // Count up each cycle, wrapping at terminal count; clear holds it at zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : slot_timer
`default_nettype wire

// File: rtl/demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demux_sequencer
// Description : Latches a 4-bit word and walks the demux address 0..3,
//               presenting word[addr] on o_data for TICK_DIV clocks per slot.
//               Busy/done handshake with optional back-to-back auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_repeat,
  input  logic [3:0] i_word_in,
  output logic       o_data,
  output logic [1:0] o_addr,
  output logic       o_busy,
  output logic       o_done
);

  import demux_pkg::*;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wreg,  w_wreg_nxt;
  logic              r_rpt,   w_rpt_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic              r_data,  w_data_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_tc;
  logic              w_tmr_clr;

  assign w_addr_inc = r_addr + ADDR_W'(1);

  // The slot counter only runs while a frame is being sent, so every frame
  // (including an auto-repeat one) starts from a fresh count of zero.
  assign w_tmr_clr = (r_state != ST_SEND);

  slot_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_slot_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_tmr_clr),
    .o_tc    (w_tc)
  );

  // Next-state and next-output decode; outputs are registered below
  always_comb begin
    w_state_nxt = r_state;
    w_wreg_nxt  = r_wreg;
    w_rpt_nxt   = r_rpt;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_addr_nxt = '0;
        w_data_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        if (i_start) begin
          w_state_nxt = ST_SEND;
          w_wreg_nxt  = i_word_in;
          w_data_nxt  = i_word_in[0];
          w_busy_nxt  = 1'b1;
        end
      end

      ST_SEND: begin
        if (w_tc) begin
          if (r_addr == c_LAST_SLOT) begin
            // Leaving slot 3: capture the repeat decision and, if repeating,
            // the next word at this same edge.
            w_state_nxt = ST_DONE;
            w_rpt_nxt   = i_repeat;
            if (i_repeat) begin
              w_wreg_nxt = i_word_in;
            end
            w_addr_nxt  = '0;
            w_data_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt = w_addr_inc;
            w_data_nxt = r_wreg[w_addr_inc];
          end
        end
      end

      ST_DONE: begin
        if (r_rpt) begin
          w_state_nxt = ST_SEND;
          w_addr_nxt  = '0;
          w_data_nxt  = r_wreg[0];
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = '0;
          w_data_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_data_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, word and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_wreg  <= '0;
      r_rpt   <= 1'b0;
      r_addr  <= '0;
      r_data  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wreg  <= w_wreg_nxt;
      r_rpt   <= w_rpt_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_data = r_data;
  assign o_addr = r_addr;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule : demux_sequencer
`default_nettype wire

// File: tb/tb_demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_sequencer
// Description : Directed self-checking bench for demux_sequencer with
//               TICK_DIV = 4, 1 and 2 instances sharing one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rpt;
  logic [3:0] word_in;

  logic       d4, d1, d2;
  logic [1:0] a4, a1, a2;
  logic       b4, b1, b2;
  logic       dn4, dn1, dn2;

  int n_checks = 0;
  int n_fail   = 0;

  demux_sequencer #(.TICK_DIV(4)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_repeat(rpt),
    .i_word_in(word_in), .o_data(d4), .o_addr(a4), .o_busy(b4), .o_done(dn4));

  demux_sequencer #(.TICK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_repeat(rpt),
    .i_word_in(word_in), .o_data(d1), .o_addr(a1), .o_busy(b1), .o_done(dn1));

  demux_sequencer #(.TICK_DIV(2)) u_dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_repeat(rpt),
    .i_word_in(word_in), .o_data(d2), .o_addr(a2), .o_busy(b2), .o_done(dn2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare and tally
  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle 1ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed {data, addr, busy, done} of the selected instance
  function automatic logic [7:0] obs(input int td);
    case (td)
      1:       return {3'b0, d1, a1, b1, dn1};
      2:       return {3'b0, d2, a2, b2, dn2};
      default: return {3'b0, d4, a4, b4, dn4};
    endcase
  endfunction

  // Downstream demux outputs {D,C,B,A} of the selected instance
  function automatic logic [7:0] demux_out(input int td);
    logic [7:0] v;
    case (td)
      1:       v = {7'b0, d1} << a1;
      2:       v = {7'b0, d2} << a2;
      default: v = {7'b0, d4} << a4;
    endcase
    return v;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    start = 1'b0;
    rpt   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Check 4*td busy cycles of word w starting at cycle 1 of the frame.
  // pert=1: drive start=1/word_in=0 during slot 1; pert=2: change word_in
  // to 4'b1000 during slot 2 (for the repeat frame).
  task automatic check_slots(input int td, input logic [3:0] w, input string tag, input int pert);
    int slot;
    for (int k = 0; k < 4 * td; k++) begin
      slot = k / td;
      check_val({tag, "_slot"}, obs(td), {3'b0, w[slot], 2'(slot), 1'b1, 1'b0});
      if (k % td == 0)
        check_val({tag, "_demux"}, demux_out(td), {7'b0, w[slot]} << slot);
      if (pert == 1 && k == td) begin
        start   = 1'b1;
        word_in = 4'b0000;
      end
      if (pert == 1 && k == 2 * td - 1) start = 1'b0;
      if (pert == 2 && k == 2 * td) word_in = 4'b1000;
      tick();
    end
  endtask

  task automatic check_done(input int td, input string tag);
    check_val({tag, "_done"}, obs(td), 8'b0000_0001);
    tick();
  endtask

  task automatic launch(input logic [3:0] w);
    word_in = w;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    rpt     = 1'b0;
    word_in = 4'b0000;
    tick();
    tick();
    // Reset state
    check_val("reset_td4", obs(4), 8'h00);
    check_val("reset_td1", obs(1), 8'h00);
    reset = 1'b0;

    // Idle with start low
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle", obs(4), 8'h00);
    end

    // Single frame, TICK_DIV=4, word 1010: B and D strobe in slots 1 and 3
    pulse_reset();
    launch(4'b1010);
    check_slots(4, 4'b1010, "frame4", 0);
    check_done(4, "frame4");
    check_val("frame4_idle", obs(4), 8'h00);

    // TICK_DIV=1, word 0110: done on the 5th cycle after start
    pulse_reset();
    launch(4'b0110);
    check_slots(1, 4'b0110, "frame1", 0);
    check_done(1, "frame1");
    check_val("frame1_idle", obs(1), 8'h00);

    // Mid-frame start and word change are ignored
    pulse_reset();
    launch(4'b1111);
    check_slots(4, 4'b1111, "midfrm", 1);
    check_done(4, "midfrm");
    check_val("midfrm_idle", obs(4), 8'h00);
    tick();
    check_val("midfrm_norestart", obs(4), 8'h00);

    // Auto-repeat, TICK_DIV=2: frame 2 carries the word sampled at end of slot 3
    pulse_reset();
    rpt = 1'b1;
    launch(4'b0001);
    check_slots(2, 4'b0001, "rpt_f1", 2);
    check_done(2, "rpt_f1");
    rpt = 1'b0;
    check_slots(2, 4'b1000, "rpt_f2", 0);
    check_done(2, "rpt_f2");
    check_val("rpt_idle", obs(2), 8'h00);

    // Reset during slot 2 abandons the frame with no done pulse
    pulse_reset();
    launch(4'b1111);
    for (int k = 0; k < 9; k++) tick();
    check_val("pre_rst_slot2", obs(4), {3'b0, 1'b1, 2'd2, 1'b1, 1'b0});
    pulse_reset();
    check_val("post_rst", obs(4), 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick();
      check_val("post_rst_nodone", obs(4), 8'h00);
    end
    launch(4'b1001);
    check_slots(4, 4'b1001, "fresh", 0);
    check_done(4, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_sequencer
`default_nettype wire
